// File: rtl/radar_control.sv
// Pulse-timing and register block: serial register file plus the
// HOLD/TX/SW/LOOK/IDLE pulse sequencer with registered strobes and chirp word.
module radar_control #(
  parameter logic [6:0] BASE = 7'd64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  saddr_i,
  input  logic [31:0] sdata_i,
  input  logic        s_strobe_i,
  output logic        tx_side_o,
  output logic        io_tx_ena_o,
  output logic        tx_strobe_o,
  output logic        rx_strobe_o,
  output logic        receive_o,
  output logic [31:0] freq_o,
  output logic [15:0] ampl_o,
  output logic [15:0] pulse_num_o
);

  typedef enum logic [2:0] {S_HOLD, S_TX, S_SW, S_LOOK, S_IDLE} state_t;

  logic [2:0]  mode_reg;
  logic [31:0] t_on_reg, t_sw_reg, t_look_reg, t_idle_reg;
  logic [15:0] ampl_reg;
  logic [31:0] fstart_reg, fincr_reg;

  logic [31:0] sw_sh, look_sh, idle_sh, fincr_sh;
  logic [15:0] ampl_sh;

  state_t      state_reg, state_next;
  state_t      after_tx, after_sw, after_look;
  logic [31:0] cnt_reg, cnt_load;
  logic        first_reg;
  logic        tx_entry, state_enter;

  logic [6:0]  offset;
  logic        addr_hit;

  assign offset   = saddr_i - BASE;
  assign addr_hit = (saddr_i >= BASE) && (offset[6:3] == 4'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_reg   <= 3'b001;
      t_on_reg   <= '0;
      t_sw_reg   <= '0;
      t_look_reg <= '0;
      t_idle_reg <= '0;
      ampl_reg   <= '0;
      fstart_reg <= '0;
      fincr_reg  <= '0;
    end else if (s_strobe_i && addr_hit) begin
      case (offset[2:0])
        3'd0: mode_reg   <= sdata_i[2:0];
        3'd1: t_on_reg   <= sdata_i;
        3'd2: t_sw_reg   <= sdata_i;
        3'd3: t_look_reg <= sdata_i;
        3'd4: t_idle_reg <= sdata_i;
        3'd5: ampl_reg   <= sdata_i[15:0];
        3'd6: fstart_reg <= sdata_i;
        default: fincr_reg <= sdata_i;
      endcase
    end
  end

  // Zero-length phases are skipped by chaining straight to the following one.
  assign after_look = (idle_sh != '0) ? S_IDLE : S_TX;
  assign after_sw   = (look_sh != '0) ? S_LOOK : after_look;
  assign after_tx   = (sw_sh   != '0) ? S_SW   : after_sw;

  always_comb begin
    state_next = state_reg;
    if (mode_reg[0]) begin
      state_next = S_HOLD;
    end else begin
      case (state_reg)
        S_HOLD: state_next = S_TX;
        S_TX:   if (cnt_reg == '0) state_next = after_tx;
        S_SW:   if (cnt_reg == '0) state_next = after_sw;
        S_LOOK: if (cnt_reg == '0) state_next = after_look;
        S_IDLE: if (cnt_reg == '0) state_next = S_TX;
        default: state_next = S_HOLD;
      endcase
    end
  end

  // TX re-entered from TX (continuous transmit) still counts as a new pulse.
  assign tx_entry    = (state_next == S_TX) && ((state_reg != S_TX) || (cnt_reg == '0));
  assign state_enter = tx_entry || (state_next != state_reg);

  always_comb begin
    cnt_load = '0;
    case (state_next)
      S_TX:   cnt_load = (t_on_reg == '0) ? 32'd0 : t_on_reg - 32'd1;
      S_SW:   cnt_load = sw_sh - 32'd1;
      S_LOOK: cnt_load = look_sh - 32'd1;
      S_IDLE: cnt_load = idle_sh - 32'd1;
      default: cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= S_HOLD;
      cnt_reg     <= '0;
      first_reg   <= 1'b1;
      sw_sh       <= '0;
      look_sh     <= '0;
      idle_sh     <= '0;
      fincr_sh    <= '0;
      ampl_sh     <= '0;
      tx_side_o   <= 1'b0;
      io_tx_ena_o <= 1'b0;
      tx_strobe_o <= 1'b0;
      rx_strobe_o <= 1'b0;
      receive_o   <= 1'b0;
      freq_o      <= '0;
      ampl_o      <= '0;
      pulse_num_o <= '0;
    end else begin
      state_reg <= state_next;
      if (state_enter)
        cnt_reg <= cnt_load;
      else if (cnt_reg != '0)
        cnt_reg <= cnt_reg - 32'd1;

      if (tx_entry) begin
        sw_sh    <= t_sw_reg;
        look_sh  <= t_look_reg;
        idle_sh  <= t_idle_reg;
        fincr_sh <= fincr_reg;
        ampl_sh  <= ampl_reg;
      end

      tx_side_o   <= mode_reg[1];
      io_tx_ena_o <= (state_next == S_TX) && !mode_reg[2];
      tx_strobe_o <= (state_next == S_TX);
      rx_strobe_o <= (state_next == S_LOOK);
      receive_o   <= (state_next == S_LOOK);

      if (tx_entry) begin
        freq_o <= fstart_reg;
        ampl_o <= mode_reg[2] ? 16'd0 : ampl_reg;
      end else if (state_next == S_TX) begin
        freq_o <= freq_o + fincr_sh;
        ampl_o <= mode_reg[2] ? 16'd0 : ampl_sh;
      end

      if (state_next == S_HOLD) begin
        pulse_num_o <= '0;
        first_reg   <= 1'b1;
      end else if (tx_entry) begin
        if (first_reg)
          first_reg <= 1'b0;
        else
          pulse_num_o <= pulse_num_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_radar_control.sv
// Randomized bench for radar_control: a pulse-timeline reference model derives
// every expected output from the pulse start cycle and its latched parameters.
module tb_radar_control;

  localparam int BASE = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [6:0]  saddr_i = '0;
  logic [31:0] sdata_i = '0;
  logic        s_strobe_i = 1'b0;
  logic        tx_side_o, io_tx_ena_o, tx_strobe_o, rx_strobe_o, receive_o;
  logic [31:0] freq_o;
  logic [15:0] ampl_o, pulse_num_o;

  radar_control #(.BASE(7'(BASE))) dut (
    .clk_i(clk_i), .rst_i(rst_i), .saddr_i(saddr_i), .sdata_i(sdata_i),
    .s_strobe_i(s_strobe_i), .tx_side_o(tx_side_o), .io_tx_ena_o(io_tx_ena_o),
    .tx_strobe_o(tx_strobe_o), .rx_strobe_o(rx_strobe_o), .receive_o(receive_o),
    .freq_o(freq_o), .ampl_o(ampl_o), .pulse_num_o(pulse_num_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Model register file
  logic [2:0]  m_mode;
  logic [31:0] m_ton, m_tsw, m_tlook, m_tidle, m_fstart, m_fincr;
  logic [15:0] m_ampl;
  // Parameters latched at the start of the current pulse
  longint      cap_ton, cap_sw, cap_look, cap_idle;
  logic [31:0] cap_fstart, cap_fincr;
  logic [15:0] cap_ampl;
  longint      cyc = 0, p_start = 0;
  bit          in_pulse = 0, first = 1;
  // Expected outputs
  logic        e_side, e_txena, e_txs, e_rx;
  logic [31:0] e_freq;
  logic [15:0] e_ampl, e_pnum;

  task automatic model_edge();
    longint p, tx_len, period;
    cyc++;
    if (rst_i) begin
      m_mode = 3'b001; m_ton = 0; m_tsw = 0; m_tlook = 0; m_tidle = 0;
      m_fstart = 0; m_fincr = 0; m_ampl = 0;
      in_pulse = 0; first = 1;
      e_side = 0; e_txena = 0; e_txs = 0; e_rx = 0; e_freq = 0; e_ampl = 0; e_pnum = 0;
      return;
    end
    if (m_mode[0]) begin
      in_pulse = 0; first = 1; e_pnum = 0;
      e_txena = 0; e_txs = 0; e_rx = 0;
    end else begin
      period = (cap_ton == 0 ? 1 : cap_ton) + cap_sw + cap_look + cap_idle;
      if (!in_pulse || (cyc - p_start) >= period) begin
        if (first) first = 0;
        else e_pnum = e_pnum + 16'd1;
        cap_ton = m_ton; cap_sw = m_tsw; cap_look = m_tlook; cap_idle = m_tidle;
        cap_fstart = m_fstart; cap_fincr = m_fincr; cap_ampl = m_ampl;
        p_start = cyc; in_pulse = 1;
      end
      p = cyc - p_start;
      tx_len = (cap_ton == 0) ? 1 : cap_ton;
      e_txs   = (p < tx_len);
      e_txena = e_txs && !m_mode[2];
      e_rx    = (p >= tx_len + cap_sw) && (p < tx_len + cap_sw + cap_look);
      if (e_txs) begin
        e_freq = cap_fstart + cap_fincr * 32'(p);
        e_ampl = m_mode[2] ? 16'd0 : cap_ampl;
      end
    end
    e_side = m_mode[1];
    if (s_strobe_i && saddr_i >= 7'(BASE) && saddr_i <= 7'(BASE + 7)) begin
      case (int'(saddr_i) - BASE)
        0: m_mode   = sdata_i[2:0];
        1: m_ton    = sdata_i;
        2: m_tsw    = sdata_i;
        3: m_tlook  = sdata_i;
        4: m_tidle  = sdata_i;
        5: m_ampl   = sdata_i[15:0];
        6: m_fstart = sdata_i;
        default: m_fincr = sdata_i;
      endcase
    end
  endtask

  task automatic compare_all();
    check("tx_side",   32'(tx_side_o),   32'(e_side));
    check("io_tx_ena", 32'(io_tx_ena_o), 32'(e_txena));
    check("tx_strobe", 32'(tx_strobe_o), 32'(e_txs));
    check("rx_strobe", 32'(rx_strobe_o), 32'(e_rx));
    check("receive",   32'(receive_o),   32'(e_rx));
    check("freq",      freq_o,           e_freq);
    check("ampl",      32'(ampl_o),      32'(e_ampl));
    check("pulse_num", 32'(pulse_num_o), 32'(e_pnum));
  endtask

  task automatic cycle(input logic r, input logic s, input int a, input logic [31:0] d);
    rst_i = r; s_strobe_i = s; saddr_i = 7'(a); sdata_i = d;
    @(posedge clk_i);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 32'h0);
  endtask

  initial begin
    int a;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 32'h0);
    idle(2);

    // Basic 4/2/8/6 pulse with wrapping chirp
    wr(BASE + 1, 4); wr(BASE + 2, 2); wr(BASE + 3, 8); wr(BASE + 4, 6);
    wr(BASE + 6, 32'hFFFF_FFF0); wr(BASE + 7, 8); wr(BASE + 5, 32'h1234);
    wr(BASE, 0);
    idle(25);
    wr(BASE + 3, 2);
    idle(45);

    // Mute and side B, then unmute mid-sequence
    wr(BASE, 3'b111); wr(BASE, 3'b110);
    idle(25);
    wr(BASE, 3'b010);
    idle(25);

    // TX 1 / LOOK 3, then all-zero continuous TX
    wr(BASE, 1); wr(BASE + 1, 0); wr(BASE + 2, 0); wr(BASE + 3, 3); wr(BASE + 4, 0);
    wr(BASE, 0);
    idle(20);
    wr(BASE + 3, 0);
    idle(10);

    // Hold mid-pulse, reset during TX, writes to foreign addresses ignored
    wr(BASE + 1, 4); wr(BASE + 3, 8); idle(8);
    wr(BASE, 1); idle(4); wr(BASE, 0); idle(2);
    cycle(1'b1, 1'b1, BASE, 0);
    wr(BASE - 1, 0); wr(BASE + 8, 0);
    idle(10);

    // Maximum-length idle phase
    wr(BASE + 1, 2); wr(BASE + 3, 1); wr(BASE + 4, 32'hFFFF_FFFF); wr(BASE, 0);
    idle(60);
    wr(BASE, 1);
    idle(3);

    // Randomized register traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        cycle(1'b1, 1'b0, 0, 32'h0);
      end else if ($urandom_range(0, 7) == 0) begin
        a = BASE - 2 + int'($urandom_range(0, 11));
        if (a >= BASE + 1 && a <= BASE + 4) d = $urandom_range(0, 5);
        else if (a == BASE) d = {29'b0, 2'($urandom), ($urandom_range(0, 5) == 0)};
        else d = $urandom;
        wr(a, d);
      end else begin
        idle(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
